// File: rtl/iomem_router_if.sv
// Master-side iomem bus: request, address, write data/strobes, registered completion and read data.
// The master holds address/data/strobes steady until it sees iomem_ready.
interface iomem_router_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_router.sv
// Routes claimed iomem accesses to one of four slaves; completes in 2+ cycles (unmapped in 1).
// Waits for s_ready up to TIMEOUT cycles, then returns all-ones; unclaimed requests get no ready.
module iomem_router #(
  parameter logic [7:0] BASE_BYTE = 8'h03,
  parameter int         TIMEOUT   = 255
) (
  input  logic           clk,
  input  logic           reset,
  iomem_router_if.slave  bus,
  output logic [3:0]     s_valid,
  input  logic [3:0]     s_ready,
  input  logic [127:0]   s_rdata,
  output logic [7:0]     s_addr,
  output logic [3:0]     s_wstrb,
  output logic [31:0]    s_wdata,
  output logic           err_decode,
  output logic           err_timeout,
  input  logic           clear_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [1:0]  sel, sel_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        ready_q, ready_nxt;
  logic [31:0] rdata_q, rdata_nxt;
  logic [3:0]  s_valid_nxt, s_wstrb_nxt;
  logic [7:0]  s_addr_nxt;
  logic [31:0] s_wdata_nxt;
  logic        dec_set, to_set;
  logic        claim, unmapped;

  assign claim    = bus.iomem_valid && (bus.iomem_addr[31:24] == BASE_BYTE);
  assign unmapped = |bus.iomem_addr[23:10];

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    cnt_nxt     = cnt;
    ready_nxt   = 1'b0;
    rdata_nxt   = rdata_q;
    s_valid_nxt = s_valid;
    s_addr_nxt  = s_addr;
    s_wstrb_nxt = s_wstrb;
    s_wdata_nxt = s_wdata;
    dec_set     = 1'b0;
    to_set      = 1'b0;
    case (state)
      IDLE: begin
        if (claim) begin
          if (unmapped) begin
            rdata_nxt = 32'h0;
            dec_set   = 1'b1;
            ready_nxt = 1'b1;
            state_nxt = DONE;
          end else begin
            sel_nxt     = bus.iomem_addr[9:8];
            s_valid_nxt = 4'b0001 << bus.iomem_addr[9:8];
            s_addr_nxt  = bus.iomem_addr[7:0];
            s_wstrb_nxt = bus.iomem_wstrb;
            s_wdata_nxt = bus.iomem_wdata;
            cnt_nxt     = 8'd0;
            state_nxt   = ACCESS;
          end
        end
      end
      ACCESS: begin
        // A ready arriving on the last allowed cycle still counts as success.
        if (s_ready[sel]) begin
          rdata_nxt   = s_rdata[{sel, 5'd0} +: 32];
          s_valid_nxt = 4'b0000;
          ready_nxt   = 1'b1;
          state_nxt   = DONE;
        end else if (cnt == CNT_LAST) begin
          rdata_nxt   = 32'hFFFF_FFFF;
          to_set      = 1'b1;
          s_valid_nxt = 4'b0000;
          ready_nxt   = 1'b1;
          state_nxt   = DONE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= 2'd0;
      cnt         <= 8'd0;
      ready_q     <= 1'b0;
      rdata_q     <= 32'h0;
      s_valid     <= 4'b0000;
      s_addr      <= 8'h0;
      s_wstrb     <= 4'h0;
      s_wdata     <= 32'h0;
      err_decode  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      cnt         <= cnt_nxt;
      ready_q     <= ready_nxt;
      rdata_q     <= rdata_nxt;
      s_valid     <= s_valid_nxt;
      s_addr      <= s_addr_nxt;
      s_wstrb     <= s_wstrb_nxt;
      s_wdata     <= s_wdata_nxt;
      // Setting a flag takes priority over clearing it in the same cycle.
      err_decode  <= dec_set | (err_decode & ~clear_err);
      err_timeout <= to_set | (err_timeout & ~clear_err);
    end
  end

endmodule

// File: tb/tb_iomem_router.sv
// Self-checking bench for iomem_router: directed scenarios plus randomized traffic vs a cycle-count model.
module tb_iomem_router;
  localparam int         TO   = 4;
  localparam logic [7:0] BASE = 8'h03;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    s_valid;
  logic [3:0]    s_ready;
  logic [127:0]  s_rdata;
  logic [7:0]    s_addr;
  logic [3:0]    s_wstrb;
  logic [31:0]   s_wdata;
  logic          err_decode;
  logic          err_timeout;
  logic          clear_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_dec = 1'b0;
  logic m_to  = 1'b0;

  always #5 clk = ~clk;

  iomem_router_if bus ();

  iomem_router #(.BASE_BYTE(BASE), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .s_addr      (s_addr),
    .s_wstrb     (s_wstrb),
    .s_wdata     (s_wdata),
    .err_decode  (err_decode),
    .err_timeout (err_timeout),
    .clear_err   (clear_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One master transaction; cycle 0 is when valid is first driven.
  // k = cycle at which the addressed slave pulses ready (0 = never).
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input int k,
                         input logic [31:0] sdata, input logic clr0, input string tag);
    logic        claimed, mapped, ok;
    int          si, done_c, last_c;
    logic [31:0] exp_rd;
    logic [3:0]  exp_sv;
    claimed = (addr[31:24] == BASE);
    mapped  = claimed && (addr[23:10] == 14'd0);
    si      = int'(addr[9:8]);
    ok      = (k >= 1) && (k <= TO);
    exp_rd  = 32'h0;
    if (!claimed) begin
      done_c = -1;
      last_c = 20;
    end else if (!mapped) begin
      done_c = 1;
      last_c = 1;
    end else begin
      done_c = (ok ? k : TO) + 1;
      last_c = done_c;
      exp_rd = ok ? sdata : 32'hFFFF_FFFF;
    end
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = addr;
    bus.iomem_wstrb = wstrb;
    bus.iomem_wdata = wdata;
    clear_err       = clr0;
    for (int i = 0; i < 4; i++) s_rdata[32*i +: 32] = $urandom;
    s_rdata[32*si +: 32] = sdata;
    s_ready = 4'($urandom);
    if (clr0) begin
      m_to  = 1'b0;
      m_dec = 1'b0;
    end
    if (claimed && !mapped) m_dec = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      tick;
      clear_err  = 1'b0;
      s_ready    = 4'($urandom);
      s_ready[si] = (c == k);
      exp_sv = (mapped && c < done_c) ? (4'b0001 << si) : 4'b0000;
      n_cmp++;
      if (s_valid !== exp_sv) begin
        n_bad++;
        $display("FAIL %s s_valid c=%0d got %b exp %b", tag, c, s_valid, exp_sv);
      end
      n_cmp++;
      if (bus.iomem_ready !== (c == done_c)) begin
        n_bad++;
        $display("FAIL %s iomem_ready c=%0d got %b exp %b", tag, c, bus.iomem_ready, (c == done_c));
      end
      if (exp_sv != 4'b0000) begin
        n_cmp++;
        if (s_addr !== addr[7:0] || s_wstrb !== wstrb || s_wdata !== wdata) begin
          n_bad++;
          $display("FAIL %s slave_req c=%0d got addr=%h wstrb=%h wdata=%h exp %h %h %h",
                   tag, c, s_addr, s_wstrb, s_wdata, addr[7:0], wstrb, wdata);
        end
      end
      if (c == done_c) begin
        if (mapped && !ok) m_to = 1'b1;
        n_cmp++;
        if (bus.iomem_rdata !== exp_rd) begin
          n_bad++;
          $display("FAIL %s iomem_rdata got %h exp %h", tag, bus.iomem_rdata, exp_rd);
        end
        n_cmp++;
        if (err_decode !== m_dec || err_timeout !== m_to) begin
          n_bad++;
          $display("FAIL %s flags got dec=%b to=%b exp dec=%b to=%b",
                   tag, err_decode, err_timeout, m_dec, m_to);
        end
      end
    end
    // Valid was still high during DONE; it must not start a second access.
    tick;
    bus.iomem_valid = 1'b0;
    s_ready         = 4'b0000;
    n_cmp++;
    if (bus.iomem_ready !== 1'b0 || s_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL %s after_done got ready=%b s_valid=%b exp 0 0000", tag, bus.iomem_ready, s_valid);
    end
    n_cmp++;
    if (err_decode !== m_dec || err_timeout !== m_to) begin
      n_bad++;
      $display("FAIL %s flags_after got dec=%b to=%b exp dec=%b to=%b",
               tag, err_decode, err_timeout, m_dec, m_to);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if (bus.iomem_ready !== 1'b0 || bus.iomem_rdata !== 32'h0 || s_valid !== 4'b0 ||
        s_addr !== 8'h0 || s_wstrb !== 4'h0 || s_wdata !== 32'h0 ||
        err_decode !== 1'b0 || err_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL %s got ready=%b rdata=%h s_valid=%b s_addr=%h s_wstrb=%h s_wdata=%h dec=%b to=%b exp all 0",
               tag, bus.iomem_ready, bus.iomem_rdata, s_valid, s_addr, s_wstrb, s_wdata,
               err_decode, err_timeout);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    check_all_zero("reset");
    reset = 1'b0;
    m_dec = 1'b0;
    m_to  = 1'b0;
  endtask

  task automatic test_read_slave1;
    run_txn(32'h0300_0104, 4'h0, 32'h0, 3, 32'hA5A5_0001, 1'b0, "read_slave1");
  endtask

  task automatic test_write_slave3;
    run_txn(32'h0300_0300, 4'hF, 32'h1234_5678, 1, 32'hC0DE_0003, 1'b0, "write_slave3");
  endtask

  task automatic test_unmapped;
    run_txn(32'h0300_0400, 4'h0, 32'h0, 1, 32'h1111_2222, 1'b0, "unmapped");
  endtask

  task automatic test_clear;
    clear_err = 1'b1;
    tick;
    clear_err = 1'b0;
    m_dec = 1'b0;
    m_to  = 1'b0;
    n_cmp++;
    if (err_decode !== 1'b0 || err_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_err got dec=%b to=%b exp 0 0", err_decode, err_timeout);
    end
  endtask

  task automatic test_timeout_clear;
    run_txn(32'h0300_0010, 4'h0, 32'h0, 0, 32'h5555_AAAA, 1'b0, "timeout");
    test_clear;
  endtask

  task automatic test_unclaimed;
    run_txn(32'h0200_0000, 4'h0, 32'h0, 2, 32'h0, 1'b0, "unclaimed");
  endtask

  task automatic test_ready_timeout_tie;
    run_txn(32'h0300_0220, 4'h3, 32'hDEAD_BEEF, TO, 32'h7777_0002, 1'b0, "tie");
  endtask

  task automatic test_set_beats_clear;
    run_txn(32'h0300_0100, 4'h0, 32'h0, 0, 32'h0, 1'b0, "timeout2");
    run_txn(32'h0301_0000, 4'h0, 32'h0, 0, 32'h0, 1'b1, "set_vs_clear");
  endtask

  task automatic test_reset_in_access;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h0300_0208;
    bus.iomem_wstrb = 4'h1;
    bus.iomem_wdata = 32'h0000_00AB;
    s_ready = 4'b0000;
    tick;
    n_cmp++;
    if (s_valid !== 4'b0100) begin
      n_bad++;
      $display("FAIL rst_access s_valid got %b exp 0100", s_valid);
    end
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bus.iomem_valid = 1'b0;
    m_dec = 1'b0;
    m_to  = 1'b0;
    check_all_zero("rst_access_after");
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if (bus.iomem_ready !== 1'b0 || s_valid !== 4'b0000) begin
        n_bad++;
        $display("FAIL rst_access_quiet got ready=%b s_valid=%b exp 0 0000", bus.iomem_ready, s_valid);
      end
    end
    run_txn(32'h0300_0208, 4'h1, 32'h0000_00AB, 2, 32'h0BAD_F00D, 1'b0, "rst_access_retry");
  endtask

  task automatic test_random;
    logic [31:0] addr;
    logic [7:0]  top;
    int          r;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin
        top = 8'($urandom);
        if (top == BASE) top = top ^ 8'h80;
        addr = {top, 24'($urandom)};
      end else if (r == 1) begin
        addr = {BASE, 14'($urandom_range(1, 16383)), 10'($urandom)};
      end else begin
        addr = {BASE, 14'd0, 10'($urandom)};
      end
      run_txn(addr, 4'($urandom), $urandom, $urandom_range(0, 7), $urandom,
              ($urandom_range(0, 7) == 0), "random");
    end
  endtask

  initial begin
    reset           = 1'b1;
    clear_err       = 1'b0;
    s_ready         = 4'b0000;
    s_rdata         = '0;
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = 32'h0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_wdata = 32'h0;
    test_reset;
    test_read_slave1;
    test_write_slave3;
    test_unmapped;
    test_timeout_clear;
    test_unclaimed;
    test_ready_timeout_tie;
    test_set_beats_clear;
    test_clear;
    test_reset_in_access;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iomem_router.md
IOMEM_ROUTER -- requirements
Module: iomem_router

Interface
REQ-001 SHALL have parameter BASE_BYTE, default 8'h03, the iomem_addr[31:24] value claimed by this block.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for a slave, range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port iomem_valid, input, 1 bit: master request.
REQ-006 SHALL have port iomem_ready, output, 1 bit: master completion, registered.
REQ-007 SHALL have port iomem_wstrb, input, 4 bits: byte write strobes; 0 means a read.
REQ-008 SHALL have port iomem_addr, input, 32 bits: master address.
REQ-009 SHALL have port iomem_wdata, input, 32 bits: master write data.
REQ-010 SHALL have port iomem_rdata, output, 32 bits: master read data, registered.
REQ-011 SHALL have port s_valid, output, 4 bits: one-hot slave request, registered.
REQ-012 SHALL have port s_ready, input, 4 bits: per-slave completion.
REQ-013 SHALL have port s_rdata, input, 128 bits: slave n read data on bits [32n+31:32n].
REQ-014 SHALL have port s_addr, output, 8 bits: offset within the slave window, registered.
REQ-015 SHALL have port s_wstrb, output, 4 bits: registered copy of iomem_wstrb.
REQ-016 SHALL have port s_wdata, output, 32 bits: registered copy of iomem_wdata.
REQ-017 SHALL have port err_decode, output, 1 bit: sticky flag set on an unmapped access.
REQ-018 SHALL have port err_timeout, output, 1 bit: sticky flag set on a slave timeout.
REQ-019 SHALL have port clear_err, input, 1 bit: clears both sticky flags.

Function
REQ-020 SHALL claim a request only when iomem_valid=1 and iomem_addr[31:24]=BASE_BYTE; all other requests are ignored and iomem_ready stays 0.
REQ-021 SHALL map slave select to iomem_addr[9:8] and treat an access as unmapped when iomem_addr[23:10] is nonzero.
REQ-022 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-023 IDLE, claimed mapped access: SHALL register s_valid[sel]=1, s_addr=iomem_addr[7:0], s_wstrb and s_wdata; SHALL clear the wait counter; next state ACCESS.
REQ-024 IDLE, claimed unmapped access: SHALL set iomem_rdata=32'h0 and err_decode=1; next state DONE; no s_valid is asserted.
REQ-025 ACCESS: SHALL sample only s_ready[sel]; the other s_ready bits are ignored.
REQ-026 ACCESS, s_ready[sel]=1: SHALL latch s_rdata slice sel into iomem_rdata, drop s_valid, go DONE; a write returns the slave rdata unchanged.
REQ-027 ACCESS, no ready and counter=TIMEOUT-1: SHALL set iomem_rdata=32'hFFFF_FFFF and err_timeout=1, drop s_valid, go DONE.
REQ-028 ACCESS, otherwise: SHALL increment the 8-bit counter; the counter never wraps.
REQ-029 ACCESS, ready and timeout in the same cycle: ready SHALL win and err_timeout SHALL NOT be set.
REQ-030 DONE: SHALL hold iomem_ready=1 for exactly one cycle, then go IDLE; a valid seen in DONE is not claimed.
REQ-031 Latency: valid at cycle 0, s_valid at 1, s_ready at k≥1 SHALL give iomem_ready at k+1 (minimum 2 cycles).
REQ-032 s_addr, s_wstrb and s_wdata SHALL stay stable while s_valid is high.
REQ-033 A flag set and clear_err in the same cycle: set SHALL win.
REQ-034 iomem_addr, iomem_wstrb and iomem_wdata are held by the master until iomem_ready; the block SHALL NOT re-sample them after IDLE.

Reset
REQ-035 With reset=1 at a clock edge: state=IDLE, iomem_ready=0, iomem_rdata=0, s_valid=0, s_addr=0, s_wstrb=0, s_wdata=0, counter=0, err_decode=0, err_timeout=0.
REQ-036 A reset during ACCESS or DONE SHALL abort the transfer with no iomem_ready pulse; s_valid SHALL be 0 in the following cycle.

Verification
REQ-037 Read 0x0300_0104, slave1 ready at cycle 3 with 0xA5A5_0001 -> s_valid=4'b0010, s_addr=0x04, iomem_ready=1 at cycle 4 only, iomem_rdata=0xA5A5_0001.
REQ-038 Write 0x0300_0300, wstrb=4'hF, wdata=0x1234_5678, slave3 ready at once -> s_wdata=0x1234_5678, s_wstrb=4'hF, iomem_ready at cycle 2.
REQ-039 Read 0x0300_0400 -> no s_valid, err_decode=1, iomem_rdata=0, one-cycle ready.
REQ-040 TIMEOUT=4, slave0 never ready -> s_valid for 4 cycles, rdata=0xFFFF_FFFF, err_timeout=1; then clear_err -> both flags 0.
REQ-041 Address 0x0200_0000 -> no s_valid, iomem_ready held 0 for 20 cycles.
REQ-042 Reset asserted in ACCESS -> s_valid=0 next cycle, no ready pulse, a new access afterwards completes normally.
